// File: rtl/inst_stream_gen.sv
// rtl/inst_stream_gen.sv - constrained-random RV32IM instruction source with valid/ready output
// Optional feature macro: INST_STREAM_GEN_NOP_EN (emit stall NOPs when LFSR A bits [7:3] are zero)
module inst_stream_gen #(
    parameter logic [31:0] SEED      = 32'hACE1_2357,
    parameter logic [15:0] NUM_INSTS = 16'd256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [2:0]  inst_class,
    output logic [15:0] inst_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam logic [31:0] NOP_WORD   = 32'h0000_007F;
    localparam logic [2:0]  NOP_CLASS  = 3'd7;
    localparam logic [31:0] SEED_A     = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] SEED_B_RAW = SEED ^ 32'h5A5A_5A5A;
    localparam logic [31:0] SEED_B     = (SEED_B_RAW == 32'h0) ? 32'h1 : SEED_B_RAW;

    state_t      state_q, state_d;
    logic [31:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  cls_q, cls_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;

    logic [31:0] a_step, b_step;
    logic [31:0] enc_word;
    logic [2:0]  enc_cls;
    logic [15:0] count_inc;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'h0);
    endfunction

    // Builds one legal word from the stepped LFSR values; returns {class, word}.
    function automatic logic [34:0] encode(input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3, cls;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = {1'b0, a[11:8]};
        rs1 = {1'b0, a[15:12]};
        rs2 = {1'b0, a[19:16]};
        f3  = a[22:20];
        f7  = 7'b0000000;
        imm = b[11:0];
        case (a[2:0])
            3'd0, 3'd1: begin
                cls = 3'd0;
                if (a[24] && (f3 <= 3'b011))
                    f7 = 7'b0000001;
                else if (a[23] && (f3 == 3'b000 || f3 == 3'b101))
                    f7 = 7'b0100000;
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            3'd2, 3'd3: begin
                cls = 3'd1;
                if (f3 == 3'b001)
                    imm = {7'b0, b[4:0]};
                else if (f3 == 3'b101)
                    imm = {1'b0, a[23], 5'b0, b[4:0]};
                w = {imm, rs1, f3, rd, 7'b0010011};
            end
            3'd4: begin
                cls = 3'd2;
                w   = {2'b00, b[9:0], rs1, 3'b010, rd, 7'b0000011};
            end
            3'd5: begin
                cls = 3'd3;
                w   = {2'b00, b[9:5], rs2, rs1, 3'b010, b[4:0], 7'b0100011};
            end
            3'd6: begin
                cls = 3'd4;
                w   = {b[11:5], rs2, rs1, a[22], a[22] & a[21], a[20], b[4:0], 7'b1100011};
            end
            default: begin
                if (!a[23]) begin
                    cls = 3'd5;
                    w   = {b[19:0], rd, 7'b1101111};
                end else begin
                    cls = 3'd6;
                    w   = {b[11:0], rs1, 3'b000, rd, 7'b1100111};
                end
            end
        endcase
        return {cls, w};
    endfunction

    // Candidate next word, derived from both LFSRs after one step.
    always_comb begin
        a_step              = lfsr_next(lfsr_a_q);
        b_step              = lfsr_next(lfsr_b_q);
        {enc_cls, enc_word} = encode(a_step, b_step);
`ifdef INST_STREAM_GEN_NOP_EN
        if (a_step[7:3] == 5'b0) begin
            enc_cls  = NOP_CLASS;
            enc_word = NOP_WORD;
        end
`endif
        // NOP handshakes never advance the count; it also saturates at NUM_INSTS.
        count_inc = ((cls_q != NOP_CLASS) && (count_q != NUM_INSTS)) ? count_q + 16'd1 : count_q;
    end

    // Next-state and output-register logic; LFSRs only move on start or handshake.
    always_comb begin
        state_d  = state_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        instr_d  = instr_q;
        cls_d    = cls_q;
        valid_d  = valid_q;
        count_d  = count_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_a_d = a_step;
                    lfsr_b_d = b_step;
                    count_d  = 16'd0;
                    if (NUM_INSTS == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                        cls_d   = NOP_CLASS;
                    end else begin
                        state_d = S_RUN;
                        done_d  = 1'b0;
                        valid_d = 1'b1;
                        instr_d = enc_word;
                        cls_d   = enc_cls;
                    end
                end
            end
            S_RUN: begin
                if (valid_q && inst_ready) begin
                    lfsr_a_d = a_step;
                    lfsr_b_d = b_step;
                    count_d  = count_inc;
                    if (count_inc == NUM_INSTS) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        instr_d = NOP_WORD;
                        cls_d   = NOP_CLASS;
                    end else begin
                        instr_d = enc_word;
                        cls_d   = enc_cls;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            instr_q  <= NOP_WORD;
            cls_q    <= NOP_CLASS;
            valid_q  <= 1'b0;
            count_q  <= 16'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            instr_q  <= instr_d;
            cls_q    <= cls_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign inst_valid  = valid_q;
    assign instruction = instr_q;
    assign inst_class  = cls_q;
    assign inst_count  = count_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_inst_stream_gen.sv
// tb/tb_inst_stream_gen.sv - scoreboard bench for inst_stream_gen (short run and long legality run)
module tb_inst_stream_gen;

    localparam logic [31:0] SEED_A = 32'hACE1_2357;
    localparam logic [31:0] SEED_B = 32'h0000_0001;

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel = 1'b0;

    logic        start_a, start_b, ready_a, ready_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] instr_a, instr_b;
    logic [2:0]  cls_a, cls_b;
    logic [15:0] cnt_a, cnt_b;

    logic        obs_valid, obs_busy, obs_done;
    logic [31:0] obs_instr;
    logic [2:0]  obs_cls;
    logic [15:0] obs_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [31:0] m_a, m_b;
    int   m_cnt, m_n;
    int   nop_seen;
    logic [7:0] hits;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign ready_a = ready & ~sel;
    assign ready_b = ready & sel;
    assign obs_valid = sel ? valid_b : valid_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_instr = sel ? instr_b : instr_a;
    assign obs_cls   = sel ? cls_b   : cls_a;
    assign obs_cnt   = sel ? cnt_b   : cnt_a;

    inst_stream_gen #(.SEED(SEED_A), .NUM_INSTS(16'd4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .inst_ready(ready_a),
        .inst_valid(valid_a), .instruction(instr_a), .inst_class(cls_a),
        .inst_count(cnt_a), .busy(busy_a), .done(done_a)
    );

    inst_stream_gen #(.SEED(SEED_B), .NUM_INSTS(16'd500)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .inst_ready(ready_b),
        .inst_valid(valid_b), .instruction(instr_b), .inst_class(cls_b),
        .inst_count(cnt_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    // Reference encoding written field by field from the instruction formats.
    function automatic exp_t ref_word(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        rd = {1'b0, a[11:8]}; rs1 = {1'b0, a[15:12]}; rs2 = {1'b0, a[19:16]};
        f3 = a[22:20];
`ifdef INST_STREAM_GEN_NOP_EN
        if (a[7:3] == 5'd0) begin
            e.w = 32'h7F; e.c = 3'd7;
            return e;
        end
`endif
        if (a[2:1] == 2'b00) begin
            f7 = 7'h00;
            if (a[24] && f3 < 3'd4) f7 = 7'h01;
            else if (a[23] && (f3 == 3'd0 || f3 == 3'd5)) f7 = 7'h20;
            e.c = 3'd0; e.w = {f7, rs2, rs1, f3, rd, 7'h33};
        end else if (a[2:1] == 2'b01) begin
            e.c = 3'd1;
            if (f3 == 3'd1)      e.w = {12'(b[4:0]), rs1, f3, rd, 7'h13};
            else if (f3 == 3'd5) e.w = {1'b0, a[23], 5'd0, b[4:0], rs1, f3, rd, 7'h13};
            else                 e.w = {b[11:0], rs1, f3, rd, 7'h13};
        end else if (a[2:0] == 3'd4) begin
            e.c = 3'd2; e.w = {2'b00, b[9:0], rs1, 3'd2, rd, 7'h03};
        end else if (a[2:0] == 3'd5) begin
            e.c = 3'd3; e.w = {2'b00, b[9:5], rs2, rs1, 3'd2, b[4:0], 7'h23};
        end else if (a[2:0] == 3'd6) begin
            if (!a[22]) f3[1] = 1'b0;
            e.c = 3'd4; e.w = {b[11:5], rs2, rs1, f3, b[4:0], 7'h63};
        end else if (!a[23]) begin
            e.c = 3'd5; e.w = {b[19:0], rd, 7'h6F};
        end else begin
            e.c = 3'd6; e.w = {b[11:0], rs1, 3'd0, rd, 7'h67};
        end
        return e;
    endfunction

    // Independent legality rules for an accepted word of a given class.
    function automatic logic legal(input logic [31:0] w, input logic [2:0] c);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       regs_ok;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        regs_ok = !w[11] && !w[19] && !w[24];
        case (c)
            3'd0: return op == 7'h33 && regs_ok &&
                         (f7 == 7'h00 || (f7 == 7'h01 && f3 <= 3'd3) ||
                          (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            3'd1: return op == 7'h13 && !w[11] && !w[19] &&
                         (f3 != 3'd1 || f7 == 7'h00) &&
                         (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20);
            3'd2: return op == 7'h03 && f3 == 3'd2 && w[31:30] == 2'b00 && !w[11] && !w[19];
            3'd3: return op == 7'h23 && f3 == 3'd2 && w[31:30] == 2'b00 && !w[19] && !w[24];
            3'd4: return op == 7'h63 && f3 != 3'd2 && f3 != 3'd3 && !w[19] && !w[24];
            3'd5: return op == 7'h6F && !w[11];
            3'd6: return op == 7'h67 && f3 == 3'd0 && !w[11] && !w[19];
            default: return w == 32'h7F;
        endcase
    endfunction

    task automatic model_init(input logic [31:0] seed, input int n);
        m_a = (seed == 0) ? 32'h1 : seed;
        m_b = ((seed ^ 32'h5A5A_5A5A) == 0) ? 32'h1 : (seed ^ 32'h5A5A_5A5A);
        m_n = n;
        m_cnt = 0;
        q.delete();
    endtask

    task automatic model_step_push();
        m_a = lfsr(m_a);
        m_b = lfsr(m_b);
        q.push_back(ref_word(m_a, m_b));
    endtask

    task automatic do_start();
        start = 1'b1;
        m_cnt = 0;
        model_step_push();
        @(negedge clk);
        start = 1'b0;
    endtask

    // One negedge-aligned cycle: decide ready, score a handshake if one occurs.
    task automatic hs_cycle(input bit rdy);
        exp_t e;
        ready = rdy;
        if (obs_valid && rdy) begin
            if (q.size() == 0) begin
                check("sb_empty", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check("word", obs_instr, e.w);
                check("class", 32'(obs_cls), 32'(e.c));
                check("legal", 32'(legal(obs_instr, obs_cls)), 32'd1);
                hits[obs_cls] = 1'b1;
                if (obs_instr == 32'h7F) nop_seen++;
                if (e.c != 3'd7) m_cnt++;
                m_a = lfsr(m_a);
                m_b = lfsr(m_b);
                if (m_cnt < m_n) q.push_back(ref_word(m_a, m_b));
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(obs_valid), 32'd0);
        check({tag, "_instr"}, obs_instr, 32'h7F);
        check({tag, "_class"}, 32'(obs_cls), 32'd7);
        check({tag, "_count"}, 32'(obs_cnt), 32'd0);
        check({tag, "_busy"},  32'(obs_busy), 32'd0);
        check({tag, "_done"},  32'(obs_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w_hold, w1, w2;
        logic [2:0]  c_hold;
        int cyc;
        hits = 8'h0;
        nop_seen = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        model_init(SEED_A, 4);
        @(negedge clk);

        // Short run of 4, ready always high.
        ready = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            check("run_valid", 32'(obs_valid), 32'd1);
            hs_cycle(1'b1);
        end
        check("end_valid", 32'(obs_valid), 32'd0);
        check("end_done", 32'(obs_done), 32'd1);
        check("end_count", 32'(obs_cnt), 32'd4);
        check("end_instr", obs_instr, 32'h7F);
        check("end_busy", 32'(obs_busy), 32'd0);
        check("end_sb", 32'(q.size()), 32'd0);

        // Restart from DONE, then backpressure for 3 cycles.
        do_start();
        check("rs_count", 32'(obs_cnt), 32'd0);
        check("rs_done", 32'(obs_done), 32'd0);
        check("rs_busy", 32'(obs_busy), 32'd1);
        hs_cycle(1'b1);
        w_hold = obs_instr;
        c_hold = obs_cls;
        for (int i = 0; i < 3; i++) begin
            hs_cycle(1'b0);
            check("bp_instr", obs_instr, w_hold);
            check("bp_class", 32'(obs_cls), 32'(c_hold));
            check("bp_valid", 32'(obs_valid), 32'd1);
        end
        for (int i = 0; i < 3; i++) hs_cycle(1'b1);
        check("bp_done", 32'(obs_done), 32'd1);
        check("bp_count", 32'(obs_cnt), 32'd4);

        // Mid-cycle async reset, then two handshakes, reset again, repeat.
        #2 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b0;
        model_init(SEED_A, 4);
        do_start();
        w1 = obs_instr;
        hs_cycle(1'b1);
        w2 = obs_instr;
        hs_cycle(1'b1);
        check("pre_rst_count", 32'(obs_cnt), 32'd2);
        #2 reset = 1'b1;
        #1 check("rst2_valid", 32'(obs_valid), 32'd0);
        check("rst2_count", 32'(obs_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_init(SEED_A, 4);
        do_start();
        check("repeat_w1", obs_instr, w1);
        hs_cycle(1'b1);
        check("repeat_w2", obs_instr, w2);
        hs_cycle(1'b1);

        // Long legality run on the 500-instruction instance with random ready.
        ready = 1'b0;
        sel = 1'b1;
        hits = 8'h0;
        nop_seen = 0;
        @(negedge clk);
        model_init(SEED_B, 500);
        for (int r = 0; r < 20; r++) begin
            do_start();
            cyc = 0;
            while (!obs_done && cyc < 5000) begin
                hs_cycle($urandom_range(0, 3) != 0);
                cyc++;
            end
            check("long_timeout", 32'(obs_done), 32'd1);
            check("long_count", 32'(obs_cnt), 32'd500);
            check("long_sb", 32'(q.size()), 32'd0);
        end
`ifdef INST_STREAM_GEN_NOP_EN
        check("nop_seen", 32'(nop_seen > 0), 32'd1);
        check("class_hits", 32'(hits), 32'hFF);
`else
        check("nop_absent", 32'(nop_seen), 32'd0);
        check("class_hits", 32'(hits), 32'h7F);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
